// File: rtl/mprj_wb_watchdog.sv
// mprj_wb_watchdog: Wishbone pass-through that terminates user-project transfers which never ack
//
// Ports:
//   core_clk, core_rst         clock, asynchronous active-high reset
//   m_cyc_i..m_dat_i           request from the management core
//   m_ack_o, m_dat_o           response to the management core (ERR_DATA on timeout)
//   s_cyc_o..s_dat_o           request forwarded to the user project, driven only in ACTIVE
//   s_ack_i, s_dat_i           response from the user project
//   clr_count                  synchronous clear of timeout_count
//   timeout_irq                one-cycle pulse per timeout
//   timeout_count              saturating count of timeouts
module mprj_wb_watchdog #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    input  logic [3:0]  m_sel_i,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    output logic        m_ack_o,
    output logic [31:0] m_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    input  logic        clr_count,
    output logic        timeout_irq,
    output logic [7:0]  timeout_count
);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr, r_dat, r_mdat;
    logic        r_irq;
    logic [7:0]  r_tcount;
    logic        w_active, w_accept, w_done, w_timeout;

    assign w_active  = r_state == ACTIVE;
    assign w_accept  = r_state == IDLE && m_cyc_i && m_stb_i;
    // An ack on the last allowed cycle wins over the timeout; a dropped cyc aborts both.
    assign w_done    = w_active && m_cyc_i && s_ack_i;
    assign w_timeout = w_active && m_cyc_i && !s_ack_i && r_cnt == TO_LAST;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_accept ? ACTIVE : IDLE;
            ACTIVE:  w_next = !m_cyc_i ? IDLE : (w_done || w_timeout) ? RESP : ACTIVE;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_mdat   <= '0;
            r_irq    <= 1'b0;
            r_tcount <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we  <= m_we_i;
                r_sel <= m_sel_i;
                r_adr <= m_adr_i;
                r_dat <= m_dat_i;
                r_cnt <= '0;
            end else if (w_active && !s_ack_i) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_done)
                r_mdat <= s_dat_i;
            else if (w_timeout)
                r_mdat <= ERR_DATA;
            r_irq <= w_timeout;
            // A clear coinciding with a timeout leaves exactly that one timeout counted.
            r_tcount <= clr_count ? {7'd0, w_timeout} :
                        (w_timeout && r_tcount != 8'hFF) ? r_tcount + 8'd1 : r_tcount;
        end
    end

    // Outputs decode straight from state so an asynchronous reset drops them at once.
    assign m_ack_o       = r_state == RESP;
    assign m_dat_o       = r_mdat;
    assign s_cyc_o       = w_active;
    assign s_stb_o       = w_active;
    assign s_we_o        = w_active && r_we;
    assign s_sel_o       = w_active ? r_sel : '0;
    assign s_adr_o       = w_active ? r_adr : '0;
    assign s_dat_o       = w_active ? r_dat : '0;
    assign timeout_irq   = r_irq;
    assign timeout_count = r_tcount;
endmodule

// File: tb/tb_mprj_wb_watchdog.sv
// tb_mprj_wb_watchdog: directed self-checking bench for mprj_wb_watchdog (TIMEOUT=4)
module tb_mprj_wb_watchdog;
    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic        m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
    logic [3:0]  m_sel_i = '0;
    logic [31:0] m_adr_i = '0, m_dat_i = '0;
    logic        m_ack_o;
    logic [31:0] m_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i = 1'b0;
    logic [31:0] s_dat_i = '0;
    logic        clr_count = 1'b0;
    logic        timeout_irq;
    logic [7:0]  timeout_count;

    int n_chk = 0;
    int n_fail = 0;

    logic        cap_we;
    logic [3:0]  cap_sel;
    logic [31:0] cap_adr, cap_dat;

    mprj_wb_watchdog #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .clr_count(clr_count), .timeout_irq(timeout_irq), .timeout_count(timeout_count)
    );

    always #5 core_clk = ~core_clk;

    // Issues one request and plays the slave: ack on ACTIVE cycle ack_at (0 = never),
    // clr_count on ACTIVE cycle clr_at (0 = never). Returns what the master saw at m_ack_o.
    task automatic run_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat, input int ack_at, input logic [31:0] sdat,
                            input int clr_at, output int stb_n, output logic acked,
                            output logic irq, output logic [31:0] rdat, output logic [7:0] tc);
        stb_n = 0; acked = 1'b0; irq = 1'b0; rdat = '0; tc = '0;
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_sel_i = sel; m_adr_i = adr; m_dat_i = dat;
        for (int i = 0; i < 40; i++) begin
            @(posedge core_clk); #1;
            if (m_ack_o) begin
                acked = 1'b1; rdat = m_dat_o; irq = timeout_irq; tc = timeout_count;
                break;
            end
            if (s_stb_o) begin
                stb_n++;
                if (stb_n == 1) begin
                    cap_we = s_we_o; cap_sel = s_sel_o; cap_adr = s_adr_o; cap_dat = s_dat_o;
                end
            end
            s_ack_i   = s_stb_o && stb_n == ack_at;
            s_dat_i   = sdat;
            clr_count = s_stb_o && stb_n == clr_at;
        end
        s_ack_i = 1'b0; clr_count = 1'b0;
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        @(posedge core_clk); #1;
    endtask

    task automatic test_reset();
        #12;
        n_chk++; if (m_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_m_ack got %b exp 0", m_ack_o); end
        n_chk++; if (m_dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_m_dat got %h exp 0", m_dat_o); end
        n_chk++; if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !== 71'h0) begin
            n_fail++; $display("FAIL rst_s_out got cyc=%b stb=%b adr=%h exp all 0", s_cyc_o, s_stb_o, s_adr_o); end
        n_chk++; if ({timeout_irq, timeout_count} !== 9'h0) begin
            n_fail++; $display("FAIL rst_irq_cnt got %b/%0d exp 0/0", timeout_irq, timeout_count); end
        @(posedge core_clk); #1;
        core_rst = 1'b0;
    endtask

    task automatic test_read();
        int n; logic a, q; logic [31:0] d; logic [7:0] c;
        run_xfer(1'b0, 4'hF, 32'h3000_0004, 32'h0, 3, 32'h1234_5678, 0, n, a, q, d, c);
        n_chk++; if (cap_adr !== 32'h3000_0004 || cap_we !== 1'b0 || cap_sel !== 4'hF) begin
            n_fail++; $display("FAIL read_req got adr=%h we=%b sel=%h exp 30000004/0/f", cap_adr, cap_we, cap_sel); end
        n_chk++; if (n !== 3) begin n_fail++; $display("FAIL read_stb_cycles got %0d exp 3", n); end
        n_chk++; if (a !== 1'b1) begin n_fail++; $display("FAIL read_ack got %b exp 1", a); end
        n_chk++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL read_data got %h exp 12345678", d); end
        n_chk++; if (q !== 1'b0 || c !== 8'd0) begin n_fail++; $display("FAIL read_irq_cnt got %b/%0d exp 0/0", q, c); end
        n_chk++; if (m_ack_o !== 1'b0) begin n_fail++; $display("FAIL read_ack_single got %b exp 0", m_ack_o); end
    endtask

    task automatic test_timeout_write();
        int n; logic a, q; logic [31:0] d; logic [7:0] c;
        run_xfer(1'b1, 4'h3, 32'h3000_0010, 32'hCAFE_F00D, 0, 32'h0, 0, n, a, q, d, c);
        n_chk++; if (cap_we !== 1'b1 || cap_sel !== 4'h3 || cap_dat !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL wr_req got we=%b sel=%h dat=%h exp 1/3/cafef00d", cap_we, cap_sel, cap_dat); end
        n_chk++; if (n !== 4) begin n_fail++; $display("FAIL to_stb_cycles got %0d exp 4", n); end
        n_chk++; if (a !== 1'b1) begin n_fail++; $display("FAIL to_ack got %b exp 1", a); end
        n_chk++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_data got %h exp deadbeef", d); end
        n_chk++; if (q !== 1'b1) begin n_fail++; $display("FAIL to_irq got %b exp 1", q); end
        n_chk++; if (c !== 8'd1) begin n_fail++; $display("FAIL to_count got %0d exp 1", c); end
        n_chk++; if (timeout_irq !== 1'b0 || m_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse_width got irq=%b ack=%b exp 0/0", timeout_irq, m_ack_o); end
    endtask

    task automatic test_ack_wins();
        int n; logic a, q; logic [31:0] d; logic [7:0] c;
        run_xfer(1'b0, 4'hF, 32'h3000_0020, 32'h0, 4, 32'hA5A5_0F0F, 0, n, a, q, d, c);
        n_chk++; if (n !== 4 || a !== 1'b1) begin n_fail++; $display("FAIL ackwin_flow got stb=%0d ack=%b exp 4/1", n, a); end
        n_chk++; if (d !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL ackwin_data got %h exp a5a50f0f", d); end
        n_chk++; if (q !== 1'b0 || c !== 8'd1) begin n_fail++; $display("FAIL ackwin_irq_cnt got %b/%0d exp 0/1", q, c); end
    endtask

    task automatic test_stb_no_cyc();
        logic seen = 1'b0;
        m_stb_i = 1'b1; m_cyc_i = 1'b0;
        repeat (3) begin @(posedge core_clk); #1; seen |= s_stb_o | m_ack_o; end
        m_stb_i = 1'b0;
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL stb_no_cyc got %b exp 0", seen); end
    endtask

    task automatic test_abort();
        logic ack_seen = 1'b0, irq_seen = 1'b0;
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h3000_0040; m_we_i = 1'b0;
        @(posedge core_clk); #1;
        n_chk++; if (s_stb_o !== 1'b1) begin n_fail++; $display("FAIL abort_start got %b exp 1", s_stb_o); end
        @(posedge core_clk); #1;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(posedge core_clk); #1;
        n_chk++; if (s_cyc_o !== 1'b0 || m_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle got cyc=%b ack=%b exp 0/0", s_cyc_o, m_ack_o); end
        s_ack_i = 1'b1; s_dat_i = 32'h5555_AAAA;
        repeat (3) begin @(posedge core_clk); #1; ack_seen |= m_ack_o; irq_seen |= timeout_irq; end
        s_ack_i = 1'b0;
        n_chk++; if (ack_seen !== 1'b0) begin n_fail++; $display("FAIL late_ack got %b exp 0", ack_seen); end
        n_chk++; if (irq_seen !== 1'b0 || timeout_count !== 8'd1) begin
            n_fail++; $display("FAIL abort_no_timeout got %b/%0d exp 0/1", irq_seen, timeout_count); end
    endtask

    task automatic test_saturation();
        int n; logic a, q; logic [31:0] d; logic [7:0] c;
        for (int i = 0; i < 300; i++) begin
            run_xfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, 0, 32'h0, 0, n, a, q, d, c);
            if (i == 253) begin
                n_chk++; if (c !== 8'd255) begin n_fail++; $display("FAIL sat_reach got %0d exp 255", c); end
            end
        end
        n_chk++; if (timeout_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d exp 255", timeout_count); end
        run_xfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, 0, 32'h0, 4, n, a, q, d, c);
        n_chk++; if (c !== 8'd1 || q !== 1'b1) begin n_fail++; $display("FAIL clr_with_timeout got %0d/%b exp 1/1", c, q); end
        clr_count = 1'b1;
        @(posedge core_clk); #1;
        clr_count = 1'b0;
        n_chk++; if (timeout_count !== 8'd0) begin n_fail++; $display("FAIL clr_alone got %0d exp 0", timeout_count); end
    endtask

    task automatic test_async_reset();
        int n; logic a, q; logic [31:0] d; logic [7:0] c;
        run_xfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, 0, 32'h0, 0, n, a, q, d, c);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h3000_0080;
        @(posedge core_clk); #1;
        @(posedge core_clk); #1;
        n_chk++; if (s_cyc_o !== 1'b1 || timeout_count !== 8'd1) begin
            n_fail++; $display("FAIL arst_pre got cyc=%b cnt=%0d exp 1/1", s_cyc_o, timeout_count); end
        #2 core_rst = 1'b1;
        #1;
        n_chk++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_adr_o !== 32'h0 || m_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL arst_drop got cyc=%b stb=%b ack=%b exp 0/0/0", s_cyc_o, s_stb_o, m_ack_o); end
        n_chk++; if (m_dat_o !== 32'h0 || timeout_count !== 8'd0 || timeout_irq !== 1'b0) begin
            n_fail++; $display("FAIL arst_outs got dat=%h cnt=%0d exp 0/0", m_dat_o, timeout_count); end
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(posedge core_clk); #1;
        core_rst = 1'b0;
        run_xfer(1'b0, 4'hF, 32'h3000_0084, 32'h0, 2, 32'h0BAD_CAFE, 0, n, a, q, d, c);
        n_chk++; if (n !== 2 || a !== 1'b1 || d !== 32'h0BAD_CAFE) begin
            n_fail++; $display("FAIL arst_recover got stb=%0d ack=%b dat=%h exp 2/1/0badcafe", n, a, d); end
    endtask

    task automatic test_back_to_back();
        int n; logic a, q; logic [31:0] d; logic [7:0] c;
        run_xfer(1'b1, 4'h1, 32'h3000_0100, 32'h1111_1111, 1, 32'h2222_2222, 0, n, a, q, d, c);
        n_chk++; if (n !== 1 || d !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_first got stb=%0d dat=%h exp 1/22222222", n, d); end
        run_xfer(1'b0, 4'h8, 32'h3000_0104, 32'h0, 1, 32'h3333_3333, 0, n, a, q, d, c);
        n_chk++; if (n !== 1 || d !== 32'h3333_3333 || cap_adr !== 32'h3000_0104) begin
            n_fail++; $display("FAIL b2b_second got stb=%0d dat=%h adr=%h exp 1/33333333/30000104", n, d, cap_adr); end
        n_chk++; if (m_dat_o !== 32'h3333_3333) begin n_fail++; $display("FAIL dat_hold got %h exp 33333333", m_dat_o); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_timeout_write();
        test_ack_wins();
        test_stb_no_cyc();
        test_abort();
        test_saturation();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mprj_wb_watchdog.md
MPRJ_WB_WATCHDOG -- requirements
Module: mprj_wb_watchdog

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: the number of ACTIVE cycles without s_ack_i before a transfer is forcibly terminated; legal range 1..65535.
REQ-002 The block SHALL have parameter ERR_DATA, default 32'hDEADBEEF: the read data returned to the master on a timed-out transfer.
REQ-003 core_clk  input  1  single clock for all state.
REQ-004 core_rst  input  1  reset; asynchronous, active-high.
REQ-005 m_cyc_i, m_stb_i, m_we_i  input  1 each  Wishbone request from the management core's mprj port.
REQ-006 m_sel_i  input  4; m_adr_i  input  32; m_dat_i  input  32  request byte select, address and write data.
REQ-007 m_ack_o  output  1; m_dat_o  output  32  response to the management core.
REQ-008 s_cyc_o, s_stb_o, s_we_o  output  1 each; s_sel_o  output  4; s_adr_o, s_dat_o  output  32  request to the user project.
REQ-009 s_ack_i  input  1; s_dat_i  input  32  response from the user project.
REQ-010 clr_count  input  1  synchronous clear of timeout_count.
REQ-011 timeout_irq  output  1  one-cycle pulse per timeout; timeout_count  output  8  saturating count of timeouts.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ACTIVE and RESP.
REQ-013 In IDLE with m_cyc_i=1 and m_stb_i=1 at a clock edge, the block SHALL latch we, sel, adr and dat, clear the cycle counter and enter ACTIVE.
REQ-014 In ACTIVE, s_cyc_o and s_stb_o SHALL be 1 and s_we/sel/adr/dat_o SHALL equal the latched values.
REQ-015 In every state other than ACTIVE, all s_* outputs SHALL be 0.
REQ-016 In ACTIVE, the cycle counter (16 bits) SHALL increment by 1 on every edge without s_ack_i.
REQ-017 On s_ack_i=1 in ACTIVE, the block SHALL capture s_dat_i into m_dat_o and enter RESP.
REQ-018 When the counter equals TIMEOUT-1 and s_ack_i=0 in ACTIVE, the block SHALL load ERR_DATA into m_dat_o, pulse timeout_irq for 1 cycle, increment timeout_count (saturating at 255) and enter RESP.
REQ-019 In RESP, m_ack_o SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-020 Latency: request accepted at edge N -> s_stb_o high after edge N; s_ack_i sampled at edge K -> m_ack_o high for the cycle after edge K.
REQ-021 m_dat_o SHALL hold its value until the next RESP load; it SHALL be meaningful only while m_ack_o=1.
REQ-022 If m_cyc_i=0 during ACTIVE, the block SHALL abort: return to IDLE, produce no m_ack_o and record no timeout.
REQ-023 If s_ack_i=1 on the same edge the counter reaches TIMEOUT-1, the ack SHALL win: real data is returned and no timeout is recorded.
REQ-024 s_ack_i in IDLE or RESP (a late ack after timeout) SHALL be ignored.
REQ-025 If clr_count and a timeout increment occur on the same edge, timeout_count SHALL become 1.
REQ-026 In IDLE, m_stb_i without m_cyc_i SHALL be ignored.
REQ-027 Write transfers SHALL follow the same flow; on a timed-out write, m_dat_o SHALL still be ERR_DATA.

Reset
REQ-028 While core_rst=1, the FSM SHALL be IDLE and all outputs SHALL be 0: m_ack_o, m_dat_o, all s_* outputs, timeout_irq and timeout_count.
REQ-029 Assertion of core_rst during ACTIVE or RESP SHALL drop s_cyc_o and m_ack_o immediately (asynchronously).
REQ-030 After reset deassertion, the first request SHALL be accepted at the first edge where m_cyc_i=m_stb_i=1.

Verification
REQ-031 Read at adr 0x3000_0004, slave acks 3 cycles after s_stb_o with 0x1234_5678 -> one m_ack_o pulse, m_dat_o=0x1234_5678, timeout_count=0.
REQ-032 Write with TIMEOUT=4 to a slave that never acks -> s_stb_o high for exactly 4 cycles, then m_ack_o with m_dat_o=0xDEADBEEF, timeout_irq pulse, timeout_count=1.
REQ-033 TIMEOUT=4 with s_ack_i asserted on the 4th ACTIVE cycle -> real data returned, timeout_irq=0, timeout_count unchanged.
REQ-034 300 consecutive timeouts -> timeout_count saturates at 255; clr_count -> 0; clr_count coincident with a timeout -> 1.
REQ-035 core_rst pulsed mid-ACTIVE -> s_cyc_o and s_stb_o fall without waiting for a clock, no m_ack_o, all outputs 0; the next request completes normally.
REQ-036 m_cyc_i dropped mid-ACTIVE -> IDLE with no ack; a late s_ack_i arriving afterwards -> no m_ack_o.
